// File: rtl/commit_pkg.sv
// Shared types and helpers for the multi-lane commit stage.
package commit_pkg;

  localparam int NUM_LANES_MAX  = 4;
  localparam int ZERO_REG       = 0;
  localparam int LANE_DATA_W    = 32;
  localparam int LANE_REG_IDX_W = 5;

  // One stage-register slot; widths track the default core configuration.
  typedef struct packed {
    logic                      valid;
    logic [LANE_REG_IDX_W-1:0] rd;
    logic                      wr_rd;
    logic                      sel_pc4;
    logic [LANE_DATA_W-1:0]    pc;
    logic [LANE_DATA_W-1:0]    result;
    logic                      excp;
    logic                      trap;
  } commit_lane_t;

  function automatic logic [2:0] popcount(input logic [NUM_LANES_MAX-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < NUM_LANES_MAX; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/commit_lane_mask.sv
// Per-lane live/commit/write-enable masks: older exception/trap kills younger
// lanes, and among same-rd writers only the youngest committing lane writes.
module commit_lane_mask
  import commit_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int REG_IDX_W = 5
) (
  input  logic [NUM_LANES-1:0]           i_valid,
  input  logic [NUM_LANES-1:0]           i_excp,
  input  logic [NUM_LANES-1:0]           i_trap,
  input  logic [NUM_LANES-1:0]           i_wr_rd,
  input  logic [NUM_LANES*REG_IDX_W-1:0] i_rd,
  input  logic                           i_flush,
  input  logic                           i_stall,
  input  logic                           i_halted,
  output logic [NUM_LANES-1:0]           o_live,
  output logic [NUM_LANES-1:0]           o_commit,
  output logic [NUM_LANES-1:0]           o_reg_we
);

  logic w_gate;
  assign w_gate = ~i_flush & ~i_stall & ~i_halted;

  // Kill is carried as a running scalar so the chain has no vector self-loop.
  always_comb begin
    logic w_kill;
    w_kill   = 1'b0;
    o_live   = '0;
    o_commit = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      o_live[i]   = i_valid[i] & w_gate & ~w_kill;
      o_commit[i] = o_live[i] & ~i_excp[i];
      w_kill      = w_kill | (o_live[i] & (i_excp[i] | i_trap[i]));
    end
  end

  always_comb begin
    logic w_waw;
    o_reg_we = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      w_waw = 1'b0;
      for (int j = i + 1; j < NUM_LANES; j++) begin
        if (o_commit[j] && i_wr_rd[j] &&
            (i_rd[j*REG_IDX_W +: REG_IDX_W] == i_rd[i*REG_IDX_W +: REG_IDX_W]))
          w_waw = 1'b1;
      end
      o_reg_we[i] = o_commit[i] & i_wr_rd[i] & ~w_waw &
                    (i_rd[i*REG_IDX_W +: REG_IDX_W] != REG_IDX_W'(ZERO_REG));
    end
  end

endmodule

// File: rtl/commit_stage.sv
// Writeback/commit stage: stage register, regfile/CSR write generation,
// sticky trap, counters and a one-cycle-delayed commit trace.
module commit_stage
  import commit_pkg::*;
#(
  parameter int NUM_LANES  = 2,
  parameter int DATA_W     = LANE_DATA_W,
  parameter int REG_IDX_W  = LANE_REG_IDX_W,
  parameter int CSR_ADDR_W = 14,
  parameter int CNT_W      = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           is_stall,
  input  logic                           is_flush,
  input  logic [NUM_LANES-1:0]           in_valid,
  input  logic [NUM_LANES*REG_IDX_W-1:0] in_rd,
  input  logic [NUM_LANES-1:0]           in_wr_rd,
  input  logic [NUM_LANES-1:0]           in_sel_pc4,
  input  logic [NUM_LANES*DATA_W-1:0]    in_pc,
  input  logic [NUM_LANES*DATA_W-1:0]    in_result,
  input  logic [NUM_LANES-1:0]           in_excp,
  input  logic [NUM_LANES-1:0]           in_trap,
  input  logic                           in_wr_csr,
  input  logic [CSR_ADDR_W-1:0]          in_csr_addr,
  output logic [NUM_LANES-1:0]           reg_we,
  output logic [NUM_LANES*REG_IDX_W-1:0] reg_idx,
  output logic [NUM_LANES*DATA_W-1:0]    reg_data,
  output logic                           csr_we,
  output logic [CSR_ADDR_W-1:0]          csr_addr,
  output logic [DATA_W-1:0]              csr_data,
  output logic [NUM_LANES-1:0]           cmt_valid,
  output logic [NUM_LANES*DATA_W-1:0]    cmt_pc,
  output logic [NUM_LANES-1:0]           cmt_excp,
  output logic [CNT_W-1:0]               instr_cnt,
  output logic [CNT_W-1:0]               cycle_cnt,
  output logic                           trap,
  output logic [7:0]                     trap_code
);

  commit_lane_t            r_lane [NUM_LANES];
  logic                    r_wr_csr;
  logic [CSR_ADDR_W-1:0]   r_csr_addr;
  logic                    r_trap;
  logic [7:0]              r_trap_code;
  logic [CNT_W-1:0]        r_instr_cnt;
  logic [CNT_W-1:0]        r_cycle_cnt;
  logic [NUM_LANES-1:0]    r_cmt_valid;
  logic [NUM_LANES-1:0]    r_cmt_excp;
  logic [DATA_W-1:0]       r_cmt_pc [NUM_LANES];

  logic [NUM_LANES-1:0]           w_valid, w_excp, w_trap, w_wr_rd;
  logic [NUM_LANES*REG_IDX_W-1:0] w_rd;
  logic [NUM_LANES-1:0]           w_live, w_commit, w_reg_we;
  logic                           w_trap_hit;
  logic [7:0]                     w_trap_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LANES; i++) r_lane[i] <= '0;
      r_wr_csr   <= 1'b0;
      r_csr_addr <= '0;
    end else if (!is_stall) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        r_lane[i].valid   <= in_valid[i];
        r_lane[i].rd      <= in_rd[i*REG_IDX_W +: REG_IDX_W];
        r_lane[i].wr_rd   <= in_wr_rd[i];
        r_lane[i].sel_pc4 <= in_sel_pc4[i];
        r_lane[i].pc      <= in_pc[i*DATA_W +: DATA_W];
        r_lane[i].result  <= in_result[i*DATA_W +: DATA_W];
        r_lane[i].excp    <= in_excp[i];
        r_lane[i].trap    <= in_trap[i];
      end
      r_wr_csr   <= in_wr_csr;
      r_csr_addr <= in_csr_addr;
    end
  end

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    assign w_valid[gi] = r_lane[gi].valid;
    assign w_excp[gi]  = r_lane[gi].excp;
    assign w_trap[gi]  = r_lane[gi].trap;
    assign w_wr_rd[gi] = r_lane[gi].wr_rd;
    assign w_rd[gi*REG_IDX_W +: REG_IDX_W]     = r_lane[gi].rd;
    assign reg_idx[gi*REG_IDX_W +: REG_IDX_W]  = r_lane[gi].rd;
    assign reg_data[gi*DATA_W +: DATA_W] = r_lane[gi].sel_pc4 ?
                                           r_lane[gi].pc + DATA_W'(4) : r_lane[gi].result;
    assign cmt_pc[gi*DATA_W +: DATA_W]   = r_cmt_pc[gi];
  end

  commit_lane_mask #(
    .NUM_LANES (NUM_LANES),
    .REG_IDX_W (REG_IDX_W)
  ) u_mask (
    .i_valid  (w_valid),
    .i_excp   (w_excp),
    .i_trap   (w_trap),
    .i_wr_rd  (w_wr_rd),
    .i_rd     (w_rd),
    .i_flush  (is_flush),
    .i_stall  (is_stall),
    .i_halted (r_trap),
    .o_live   (w_live),
    .o_commit (w_commit),
    .o_reg_we (w_reg_we)
  );

  // Younger trapping lanes are already killed, so the oldest hit is the only one.
  always_comb begin
    w_trap_hit  = 1'b0;
    w_trap_code = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (w_commit[i] && r_lane[i].trap) begin
        w_trap_hit  = 1'b1;
        w_trap_code = r_lane[i].result[7:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trap      <= 1'b0;
      r_trap_code <= '0;
      r_instr_cnt <= '0;
      r_cycle_cnt <= '0;
      r_cmt_valid <= '0;
      r_cmt_excp  <= '0;
      for (int i = 0; i < NUM_LANES; i++) r_cmt_pc[i] <= '0;
    end else begin
      if (w_trap_hit) begin
        r_trap      <= 1'b1;
        r_trap_code <= w_trap_code;
      end
      if (!r_trap) begin
        r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
        r_instr_cnt <= r_instr_cnt + CNT_W'(popcount(NUM_LANES_MAX'(w_commit)));
      end
      r_cmt_valid <= w_live;
      r_cmt_excp  <= w_live & w_excp;
      for (int i = 0; i < NUM_LANES; i++)
        r_cmt_pc[i] <= w_live[i] ? r_lane[i].pc : '0;
    end
  end

  assign reg_we    = w_reg_we;
  assign csr_we    = w_commit[0] & r_wr_csr;
  assign csr_addr  = r_csr_addr;
  assign csr_data  = r_lane[0].result;
  assign cmt_valid = r_cmt_valid;
  assign cmt_excp  = r_cmt_excp;
  assign instr_cnt = r_instr_cnt;
  assign cycle_cnt = r_cycle_cnt;
  assign trap      = r_trap;
  assign trap_code = r_trap_code;

endmodule

// File: tb/tb_commit_stage.sv
// Directed bench for commit_stage (2 lanes): dual commit, WAW, exception,
// pc+4 wrap/CSR, stall/flush, trap and asynchronous reset.
module tb_commit_stage;

  localparam int NL = 2;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 14;
  localparam int KW = 64;

  logic            clk;
  logic            rst_n;
  logic            is_stall, is_flush;
  logic [NL-1:0]    in_valid, in_wr_rd, in_sel_pc4, in_excp, in_trap;
  logic [NL*RW-1:0] in_rd;
  logic [NL*DW-1:0] in_pc, in_result;
  logic            in_wr_csr;
  logic [CW-1:0]    in_csr_addr;
  logic [NL-1:0]    reg_we, cmt_valid, cmt_excp;
  logic [NL*RW-1:0] reg_idx;
  logic [NL*DW-1:0] reg_data, cmt_pc;
  logic            csr_we;
  logic [CW-1:0]    csr_addr;
  logic [DW-1:0]    csr_data;
  logic [KW-1:0]    instr_cnt, cycle_cnt;
  logic            trap;
  logic [7:0]       trap_code;

  int vectors = 0;
  int fails   = 0;
  int edges   = 0;
  logic [KW-1:0] frozen_cyc;

  commit_stage #(
    .NUM_LANES(NL), .DATA_W(DW), .REG_IDX_W(RW), .CSR_ADDR_W(CW), .CNT_W(KW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .is_stall(is_stall), .is_flush(is_flush),
    .in_valid(in_valid), .in_rd(in_rd), .in_wr_rd(in_wr_rd), .in_sel_pc4(in_sel_pc4),
    .in_pc(in_pc), .in_result(in_result), .in_excp(in_excp), .in_trap(in_trap),
    .in_wr_csr(in_wr_csr), .in_csr_addr(in_csr_addr),
    .reg_we(reg_we), .reg_idx(reg_idx), .reg_data(reg_data),
    .csr_we(csr_we), .csr_addr(csr_addr), .csr_data(csr_data),
    .cmt_valid(cmt_valid), .cmt_pc(cmt_pc), .cmt_excp(cmt_excp),
    .instr_cnt(instr_cnt), .cycle_cnt(cycle_cnt), .trap(trap), .trap_code(trap_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clock edges seen out of reset; equals cycle_cnt until the trap freezes it.
  always @(posedge clk) if (rst_n) edges <= edges + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
    $display("vec %0d %s observed=0x%0h expected=0x%0h", vectors, tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    in_valid = '0; in_wr_rd = '0; in_sel_pc4 = '0; in_excp = '0; in_trap = '0;
    in_rd = '0; in_pc = '0; in_result = '0; in_wr_csr = 1'b0; in_csr_addr = '0;
  endtask

  task automatic set_lane(input int i, input logic [4:0] rd, input logic wr, input logic sel,
                          input logic [31:0] pc, input logic [31:0] res,
                          input logic excp, input logic trp);
    in_valid[i]          = 1'b1;
    in_rd[i*RW +: RW]    = rd;
    in_wr_rd[i]          = wr;
    in_sel_pc4[i]        = sel;
    in_pc[i*DW +: DW]    = pc;
    in_result[i*DW +: DW] = res;
    in_excp[i]           = excp;
    in_trap[i]           = trp;
  endtask

  initial begin
    rst_n = 1'b0; is_stall = 1'b0; is_flush = 1'b0;
    clear_in();
    tick(); tick();
    chk("rst_reg_we",    64'(reg_we),    64'h0);
    chk("rst_trap",      64'(trap),      64'h0);
    chk("rst_instr_cnt", instr_cnt,      64'h0);
    chk("rst_cycle_cnt", cycle_cnt,      64'h0);
    chk("rst_cmt_valid", 64'(cmt_valid), 64'h0);
    rst_n = 1'b1;

    // Dual commit
    set_lane(0, 5'd3, 1'b1, 1'b0, 32'h100, 32'h11, 1'b0, 1'b0);
    set_lane(1, 5'd4, 1'b1, 1'b0, 32'h104, 32'h22, 1'b0, 1'b0);
    tick();
    chk("dual_reg_we",   64'(reg_we),   64'h3);
    chk("dual_reg_idx",  64'(reg_idx),  64'h83);
    chk("dual_reg_data", reg_data,      64'h00000022_00000011);
    clear_in();
    tick();
    chk("dual_instr_cnt", instr_cnt,      64'd2);
    chk("dual_cmt_valid", 64'(cmt_valid), 64'h3);
    chk("dual_cmt_pc",    cmt_pc,         64'h00000104_00000100);
    chk("dual_cycle_cnt", cycle_cnt,      64'(edges));

    // WAW on rd5: youngest lane wins
    set_lane(0, 5'd5, 1'b1, 1'b0, 32'h200, 32'hA, 1'b0, 1'b0);
    set_lane(1, 5'd5, 1'b1, 1'b0, 32'h204, 32'hB, 1'b0, 1'b0);
    tick();
    chk("waw_reg_we",   64'(reg_we), 64'h2);
    chk("waw_reg_data", reg_data,    64'h0000000B_0000000A);
    clear_in();
    tick();
    chk("waw_instr_cnt", instr_cnt, 64'd4);

    // Exception on lane0 kills lane1
    set_lane(0, 5'd1, 1'b1, 1'b0, 32'h300, 32'h33, 1'b1, 1'b0);
    set_lane(1, 5'd6, 1'b1, 1'b0, 32'h304, 32'h44, 1'b0, 1'b0);
    tick();
    chk("excp_reg_we", 64'(reg_we), 64'h0);
    clear_in();
    tick();
    chk("excp_cmt_valid", 64'(cmt_valid), 64'h1);
    chk("excp_cmt_excp",  64'(cmt_excp),  64'h1);
    chk("excp_instr_cnt", instr_cnt,      64'd4);

    // pc+4 wrap, rd0 write suppression, CSR write
    set_lane(0, 5'd7, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h55, 1'b0, 1'b0);
    set_lane(1, 5'd0, 1'b1, 1'b0, 32'h0, 32'h77, 1'b0, 1'b0);
    in_wr_csr = 1'b1; in_csr_addr = 14'h305;
    tick();
    chk("wrap_reg_we",   64'(reg_we),   64'h1);
    chk("wrap_reg_data", reg_data,      64'h00000077_00000000);
    chk("csr_we",        64'(csr_we),   64'h1);
    chk("csr_addr",      64'(csr_addr), 64'h305);
    chk("csr_data",      64'(csr_data), 64'h55);
    clear_in();
    tick();
    chk("wrap_instr_cnt", instr_cnt, 64'd6);

    // Stall three cycles, then release together with flush
    set_lane(0, 5'd8, 1'b1, 1'b0, 32'h400, 32'h88, 1'b0, 1'b0);
    set_lane(1, 5'd9, 1'b1, 1'b0, 32'h404, 32'h99, 1'b0, 1'b0);
    tick();
    clear_in();
    is_stall = 1'b1;
    #1 chk("stall1_reg_we", 64'(reg_we), 64'h0);
    tick();
    chk("stall2_reg_we", 64'(reg_we), 64'h0);
    tick();
    chk("stall3_reg_we",    64'(reg_we), 64'h0);
    chk("stall_instr_cnt",  instr_cnt,   64'd6);
    chk("stall_cycle_cnt",  cycle_cnt,   64'(edges));
    is_stall = 1'b0; is_flush = 1'b1;
    #1 chk("flush_reg_we", 64'(reg_we), 64'h0);
    tick();
    is_flush = 1'b0;
    chk("flush_instr_cnt", instr_cnt,      64'd6);
    chk("flush_cmt_valid", 64'(cmt_valid), 64'h0);

    // Trap on lane0: its write happens, lane1 is killed, then everything freezes
    set_lane(0, 5'd10, 1'b1, 1'b0, 32'h500, 32'h1, 1'b0, 1'b1);
    set_lane(1, 5'd11, 1'b1, 1'b0, 32'h504, 32'h99, 1'b0, 1'b0);
    tick();
    chk("trap_reg_we",  64'(reg_we), 64'h1);
    chk("trap_pre",     64'(trap),   64'h0);
    set_lane(0, 5'd12, 1'b1, 1'b0, 32'h600, 32'h5, 1'b0, 1'b0);
    set_lane(1, 5'd13, 1'b1, 1'b0, 32'h604, 32'h6, 1'b0, 1'b0);
    tick();
    frozen_cyc = 64'(edges);
    chk("trap_flag",      64'(trap),      64'h1);
    chk("trap_code",      64'(trap_code), 64'h01);
    chk("trap_instr_cnt", instr_cnt,      64'd7);
    chk("trap_cmt_valid", 64'(cmt_valid), 64'h1);
    chk("trap_cycle_cnt", cycle_cnt,      frozen_cyc);
    chk("post_trap_reg_we", 64'(reg_we), 64'h0);
    tick(); tick(); tick();
    chk("frozen_cycle_cnt", cycle_cnt, frozen_cyc);
    chk("frozen_instr_cnt", instr_cnt, 64'd7);
    chk("frozen_reg_we",    64'(reg_we), 64'h0);
    chk("sticky_trap",      64'(trap),   64'h1);

    // Asynchronous reset mid-cycle
    #2 rst_n = 1'b0;
    #1;
    chk("arst_trap",      64'(trap),      64'h0);
    chk("arst_trap_code", 64'(trap_code), 64'h0);
    chk("arst_instr_cnt", instr_cnt,      64'h0);
    chk("arst_cycle_cnt", cycle_cnt,      64'h0);
    chk("arst_reg_we",    64'(reg_we),    64'h0);
    chk("arst_reg_data",  reg_data,       64'h0);
    chk("arst_cmt_pc",    cmt_pc,         64'h0);
    tick();
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
